// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-stage pipeline register with operand forwarding and hazard stall.
//
// Holds one fetch payload and resolves NPORT register-read operands. Each operand comes from
// the youngest downstream producer (index 0 = EX) that writes the same non-zero register. If
// there is no such producer, the register file supplies it. The stage stalls when a consumed
// operand's winning producer has not produced its result yet.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid/in_allowin    handshake with fetch; in_bus is the incoming payload
//   out_valid/out_allowin  handshake with execute; hold_bus is the held payload
//   flush                  kill the held instruction and any same-cycle incoming payload
//   rd_addr/rd_need        per-port read address and consume flag (decoded from hold_bus)
//   rf_rdata               per-port register-file data
//   fwd_we/addr/data/pend  per-producer write enable, destination, result, result-not-ready
//   src_data               per-port resolved operand
//   stall, stall_cnt       hazard stall flag and saturating stall-cycle count
module id_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NPORT = 2,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned BUS_W = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_allowin,
  input  logic [BUS_W-1:0]      in_bus,
  output logic                  out_valid,
  input  logic                  out_allowin,
  output logic [BUS_W-1:0]      hold_bus,
  input  logic                  flush,
  input  logic [NPORT*AW-1:0]   rd_addr,
  input  logic [NPORT-1:0]      rd_need,
  input  logic [NPORT*XLEN-1:0] rf_rdata,
  input  logic [NSRC-1:0]       fwd_we,
  input  logic [NSRC*AW-1:0]    fwd_addr,
  input  logic [NSRC*XLEN-1:0]  fwd_data,
  input  logic [NSRC-1:0]       fwd_pend,
  output logic [NPORT*XLEN-1:0] src_data,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic             valid_q, valid_d;
  logic [BUS_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NPORT-1:0] pend_hit;
  logic             ready_go;

  // Walk producers from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    src_data = rf_rdata;
    pend_hit = '0;
    for (int p = 0; p < int'(NPORT); p++) begin
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
        if (fwd_we[i] && (fwd_addr[i*AW +: AW] == rd_addr[p*AW +: AW]) &&
            (rd_addr[p*AW +: AW] != '0)) begin
          src_data[p*XLEN +: XLEN] = fwd_data[i*XLEN +: XLEN];
          pend_hit[p]              = fwd_pend[i];
        end
      end
    end
  end

  // Only consumed operands whose winning producer is still pending block the stage.
  assign stall      = valid_q & |(rd_need & pend_hit);
  assign ready_go   = ~stall;
  assign out_valid  = valid_q & ready_go & ~flush;
  assign in_allowin = ~valid_q | (ready_go & out_allowin);

  always_comb begin
    valid_d = valid_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_allowin) begin
      valid_d = in_valid;
    end
    if (in_valid && in_allowin && !flush) begin
      hold_d = in_bus;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hold_bus  = hold_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NPORT = 2;
  localparam int unsigned NSRC  = 3;
  localparam int unsigned BUS_W = 64;
  localparam int unsigned CNT_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_allowin;
  logic [BUS_W-1:0]      in_bus;
  logic                  out_valid;
  logic                  out_allowin;
  logic [BUS_W-1:0]      hold_bus;
  logic                  flush;
  logic [NPORT*AW-1:0]   rd_addr;
  logic [NPORT-1:0]      rd_need;
  logic [NPORT*XLEN-1:0] rf_rdata;
  logic [NSRC-1:0]       fwd_we;
  logic [NSRC*AW-1:0]    fwd_addr;
  logic [NSRC*XLEN-1:0]  fwd_data;
  logic [NSRC-1:0]       fwd_pend;
  logic [NPORT*XLEN-1:0] src_data;
  logic                  stall;
  logic [CNT_W-1:0]      stall_cnt;

  id_operand_stage #(
    .XLEN (XLEN),
    .AW   (AW),
    .NPORT(NPORT),
    .NSRC (NSRC),
    .BUS_W(BUS_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_allowin (in_allowin),
    .in_bus     (in_bus),
    .out_valid  (out_valid),
    .out_allowin(out_allowin),
    .hold_bus   (hold_bus),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_need    (rd_need),
    .rf_rdata   (rf_rdata),
    .fwd_we     (fwd_we),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .fwd_pend   (fwd_pend),
    .src_data   (src_data),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference state: is an instruction held, what payload, how many stalled cycles.
  logic             m_valid = 1'b0;
  logic [BUS_W-1:0] m_hold  = '0;
  logic [CNT_W-1:0] m_cnt   = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // First (youngest) producer writing this port's non-zero register, or -1.
  function automatic int winner(input int p);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    if (a == 0) return -1;
    for (int i = 0; i < int'(NSRC); i++)
      if (fwd_we[i] && fwd_addr[i*AW +: AW] == a) return i;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] exp_src(input int p);
    int w;
    w = winner(p);
    if (w < 0) return rf_rdata[p*XLEN +: XLEN];
    return fwd_data[w*XLEN +: XLEN];
  endfunction

  function automatic logic exp_hazard();
    int w;
    for (int p = 0; p < int'(NPORT); p++) begin
      w = winner(p);
      if (rd_need[p] && w >= 0 && fwd_pend[w]) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic st, alw;
    if (reset) begin
      m_valid <= 1'b0;
      m_hold  <= '0;
      m_cnt   <= '0;
    end else begin
      st  = m_valid && exp_hazard();
      alw = !m_valid || (!st && out_allowin);
      if (st && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
      if (flush) m_valid <= 1'b0;
      else if (alw) m_valid <= in_valid;
      if (in_valid && alw && !flush) m_hold <= in_bus;
    end
  end

  always @(negedge clk) begin
    logic [NPORT*XLEN-1:0] es;
    logic est;
    if (chk_en) begin
      for (int p = 0; p < int'(NPORT); p++) es[p*XLEN +: XLEN] = exp_src(p);
      est = m_valid && exp_hazard();
      check("stall", 128'(stall), 128'(est));
      check("out_valid", 128'(out_valid), 128'(m_valid && !est && !flush));
      check("in_allowin", 128'(in_allowin), 128'(!m_valid || (!est && out_allowin)));
      check("hold_bus", 128'(hold_bus), 128'(m_hold));
      check("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
      check("src_data", 128'(src_data), 128'(es));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_we   = '0;
    fwd_addr = '0;
    fwd_data = '0;
    fwd_pend = '0;
    rd_addr  = '0;
    rd_need  = '0;
  endtask

  task automatic load(input logic [BUS_W-1:0] b);
    in_valid = 1'b1;
    in_bus   = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_bus      = '0;
    out_allowin = 1'b1;
    flush       = 1'b0;
    rf_rdata    = {32'hBBBB_0001, 32'hAAAA_0000};
    clear_fwd();
    step();
    step();
    chk_en = 1'b1;
    reset  = 1'b0;
    #2;
    check("lit_reset_out_valid", 128'(out_valid), 128'(0));
    check("lit_reset_hold_bus", 128'(hold_bus), 128'(0));
    check("lit_reset_stall_cnt", 128'(stall_cnt), 128'(0));
    check("lit_reset_stall", 128'(stall), 128'(0));

    // Basic pass-through.
    load(64'hA5);
    #2;
    check("lit_basic_out_valid", 128'(out_valid), 128'(1));
    check("lit_basic_hold_bus", 128'(hold_bus), 128'(64'hA5));
    check("lit_basic_src", 128'(src_data), 128'({32'hBBBB_0001, 32'hAAAA_0000}));
    out_allowin = 1'b0;

    // Youngest non-pending producer wins.
    rd_addr[0 +: AW]  = 5'd5;
    fwd_addr          = {5'd5, 5'd5, 5'd5};
    fwd_data          = {32'h33, 32'h22, 32'h11};
    fwd_we            = 3'b101;
    #2;
    check("lit_prio_src0", 128'(src_data[0 +: XLEN]), 128'(32'h11));
    fwd_we = 3'b100;
    #1;
    check("lit_prio_src2", 128'(src_data[0 +: XLEN]), 128'(32'h33));
    step();

    // Load-use stall for one cycle.
    clear_fwd();
    out_allowin = 1'b1;
    load(64'hB6);
    rd_addr[AW +: AW] = 5'd7;
    rd_need           = 2'b10;
    fwd_we            = 3'b001;
    fwd_addr[0 +: AW] = 5'd7;
    fwd_pend          = 3'b001;
    #2;
    check("lit_lu_stall", 128'(stall), 128'(1));
    check("lit_lu_allowin", 128'(in_allowin), 128'(0));
    step();
    fwd_we             = 3'b010;
    fwd_pend           = 3'b000;
    fwd_addr           = '0;
    fwd_addr[AW +: AW] = 5'd7;
    fwd_data[XLEN +: XLEN] = 32'h2222;
    #2;
    check("lit_lu_cnt", 128'(stall_cnt), 128'(1));
    check("lit_lu_out_valid", 128'(out_valid), 128'(1));
    check("lit_lu_src1", 128'(src_data[XLEN +: XLEN]), 128'(32'h2222));
    step();

    // Pending matches that must not stall.
    clear_fwd();
    load(64'hC7);
    out_allowin       = 1'b0;
    rd_addr[AW +: AW] = 5'd7;
    rd_need           = 2'b00;
    fwd_we            = 3'b001;
    fwd_addr[0 +: AW] = 5'd7;
    fwd_pend          = 3'b001;
    fwd_data[0 +: XLEN] = 32'h7777;
    #2;
    check("lit_noneed_stall", 128'(stall), 128'(0));
    step();
    rd_addr  = '0;
    rd_need  = 2'b01;
    fwd_addr = '0;
    #2;
    check("lit_r0_stall", 128'(stall), 128'(0));
    check("lit_r0_src0", 128'(src_data[0 +: XLEN]), 128'(32'hAAAA_0000));
    step();

    // Flush discards both held and incoming payloads.
    clear_fwd();
    out_allowin = 1'b1;
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_bus      = 64'hDEAD;
    #2;
    check("lit_flush_out_valid", 128'(out_valid), 128'(0));
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #2;
    check("lit_flush_after_valid", 128'(out_valid), 128'(0));
    check("lit_flush_hold_bus", 128'(hold_bus), 128'(64'hC7));

    // Saturating stall counter.
    load(64'hE8);
    rd_addr[0 +: AW]  = 5'd3;
    rd_need           = 2'b01;
    fwd_we            = 3'b001;
    fwd_addr[0 +: AW] = 5'd3;
    fwd_pend          = 3'b001;
    repeat (20) step();
    #1;
    check("lit_sat_cnt", 128'(stall_cnt), 128'(15));
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("lit_sat_reset_cnt", 128'(stall_cnt), 128'(0));
    check("lit_sat_reset_valid", 128'(out_valid), 128'(0));

    // Randomised traffic; small register space so matches are frequent.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bus      = {$urandom, $urandom};
      out_allowin = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 11) == 0);
      rd_need     = NPORT'($urandom);
      rf_rdata    = {$urandom, $urandom};
      fwd_we      = NSRC'($urandom);
      fwd_pend    = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
      for (int p = 0; p < int'(NPORT); p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3));
      for (int i = 0; i < int'(NSRC); i++) begin
        fwd_addr[i*AW +: AW]     = AW'($urandom_range(0, 3));
        fwd_data[i*XLEN +: XLEN] = $urandom;
      end
      step();
    end
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised decode-stage pipeline register with an operand-forwarding and hazard-stall network.
- Holds one instruction payload between the fetch and execute stages, and resolves up to NPORT register-read operands.
- Operand sources are NSRC downstream producer stages, with fixed youngest-first priority, falling back to the register file.
- Stalls when the winning producer's data is not yet available (load-use and multi-cycle results).
- Supports flush and keeps a saturating stall-cycle counter.

Parameters:
- XLEN, 32, operand data width
- AW, 5, register address width
- NPORT, 2, number of operand read ports
- NSRC, 3, number of forwarding sources; index 0 is youngest (EX), NSRC-1 oldest (WB)
- BUS_W, 64, payload width from fetch
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  fetch stage has payload
- in_allowin  out  1  stage can accept payload this cycle
- in_bus  in  BUS_W  payload from fetch
- out_valid  out  1  stage presents a resolved instruction
- out_allowin  in  1  execute stage can accept
- hold_bus  out  BUS_W  registered payload (feeds the external decoder and execute bus)
- flush  in  1  kill the held instruction (branch taken / redirect)
- rd_addr  in  NPORT*AW  read address per port, decoded from hold_bus
- rd_need  in  NPORT  port is actually consumed by the instruction
- rf_rdata  in  NPORT*XLEN  register-file read data per port
- fwd_we  in  NSRC  producer i writes a register
- fwd_addr  in  NSRC*AW  producer i destination
- fwd_data  in  NSRC*XLEN  producer i result
- fwd_pend  in  NSRC  producer i result not yet valid (load in EX, busy divider)
- src_data  out  NPORT*XLEN  resolved operand per port
- stall  out  1  stage is blocked by a data hazard
- stall_cnt  out  CNT_W  cycles spent stalled

Behaviour:
- State:
  - valid register
  - payload register (hold_bus)
  - stall_cnt register
- Reset: valid=0, hold_bus=0, stall_cnt=0; therefore out_valid=0 and stall=0.
- Match rule: match[p][i] = fwd_we[i] & (fwd_addr[i]==rd_addr[p]) & (rd_addr[p]!=0). Register 0 never matches.
- Priority per port: the lowest matching index wins.
  - src_data[p] = fwd_data[winner], or rf_rdata[p] if there is no match.
  - A pending older match is irrelevant when a younger non-pending match wins.
- stall = valid & OR over p of (rd_need[p] & match on the winner & fwd_pend[winner]).
  - Ports with rd_need=0 never stall, even if they match a pending producer.
- ready_go = ~stall.
- out_valid = valid & ready_go & ~flush.
- in_allowin = ~valid | (ready_go & out_allowin).
- Valid update, in priority order:
  - reset: 0
  - flush: 0; any same-cycle incoming payload is discarded
  - in_allowin: in_valid
  - otherwise hold
- Payload update: hold_bus <= in_bus when in_valid & in_allowin & ~flush. Otherwise hold; payload is not cleared on flush.
- Latency: payload accepted at edge N; out_valid may assert in cycle N+1 (combinational resolve, zero added cycles).
- Stall persistence: while stalled, the payload and valid are held.
  - The forwarded value is re-evaluated each cycle.
  - No operand capture occurs; sources must keep presenting data until consumed.
- Back-pressure: out_allowin=0 with valid=1 holds the payload; in_allowin=0.
- stall_cnt increments by 1 each cycle stall=1, saturates at all-ones, and is cleared only by reset.
- Reset mid-stall: next cycle valid=0, stall_cnt=0; any in-flight payload is lost.
- Flush during stall: valid drops next cycle; stall_cnt counts the flush cycle if stall=1 that cycle.

Test Plan:
- Reset, then in_valid=1, in_bus=64'hA5, out_allowin=1, no matches → out_valid=1 in the next cycle, hold_bus=64'hA5, src_data=rf_rdata, stall_cnt=0.
- Forward priority, rd_addr[0]=5:
  - src0 (addr 5, data 0x11, not pending) and src2 (addr 5, data 0x33) both match → src_data[0]=0x11.
  - Drop fwd_we[0] → src_data[0]=0x33.
- Load-use: rd_addr[1]=7, rd_need[1]=1, src0 addr 7 with fwd_pend=1 for 1 cycle → stall=1 and in_allowin=0 for 1 cycle, stall_cnt=1. Next cycle, with the load now in src1 not pending, out_valid=1 and src_data[1]=fwd_data[1].
- Pending match with rd_need=0, and rd_addr=0 matching src0 addr 0 pending → no stall, src_data=rf_rdata.
- Flush together with in_valid=1 → valid=0 next cycle, out_valid=0, hold_bus unchanged.
- Saturation with CNT_W=4: hold a pending hazard for 20 cycles → stall_cnt stops at 15. Then assert reset → 0.
